cmd_axis_tx: RTL and testbench



---
 rtl/graphite_cmd_pkg.sv | 17 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/cmd_axis_tx.sv | 123 ++++++++++++
 tb/tb_cmd_axis_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/graphite_cmd_pkg.sv
// rtl/graphite_cmd_pkg.sv - shared types, widths and parameter checks for the command stream transmitter
package graphite_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } cmd_tx_state_t;

    localparam int DEF_STREAM_WIDTH = 16;
    localparam int CMD_WORD_WIDTH   = 2 * DEF_STREAM_WIDTH;

    function automatic logic fifo_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count, show-ahead read data
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full comes from the registered count, so a pop never frees room for a same-cycle push.
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cmd_axis_tx.sv
// rtl/cmd_axis_tx.sv - host word FIFO plus MSB-first two-beat stream serializer; CMD_AXIS_TX_OVERFLOW_EN adds sticky overflow_o
module cmd_axis_tx
    import graphite_cmd_pkg::*;
#(
    parameter int CMD_STREAM_WIDTH = DEF_STREAM_WIDTH,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic                          host_wr_i,
    input  logic [2*CMD_STREAM_WIDTH-1:0] host_data_i,
    output logic                          host_full_o,
    output logic [$clog2(FIFO_DEPTH):0]   host_level_o,
    output logic                          cmd_axis_tvalid_o,
    input  logic                          cmd_axis_tready_i,
    output logic [CMD_STREAM_WIDTH-1:0]   cmd_axis_tdata_o,
    output logic                          idle_o
`ifdef CMD_AXIS_TX_OVERFLOW_EN
    ,
    output logic                          overflow_o
`endif
);

    localparam int WORD_W = 2 * CMD_STREAM_WIDTH;

    if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    cmd_tx_state_t               state, state_nx;
    logic                        tvalid_nx;
    logic [CMD_STREAM_WIDTH-1:0] tdata_nx;
    logic [CMD_STREAM_WIDTH-1:0] lo_half, lo_half_nx;
    logic                        fifo_pop;
    logic                        fifo_empty;
    logic [WORD_W-1:0]           fifo_dout;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_i   (reset_i),
        .push      (host_wr_i),
        .push_data (host_data_i),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (host_full_o),
        .empty     (fifo_empty),
        .count     (host_level_o)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state             <= IDLE;
            cmd_axis_tvalid_o <= 1'b0;
            cmd_axis_tdata_o  <= '0;
            lo_half           <= '0;
        end else begin
            state             <= state_nx;
            cmd_axis_tvalid_o <= tvalid_nx;
            cmd_axis_tdata_o  <= tdata_nx;
            lo_half           <= lo_half_nx;
        end
    end

    // Only the low half needs holding: the high half goes straight into tdata on pop.
    always_comb begin
        state_nx   = state;
        tvalid_nx  = cmd_axis_tvalid_o;
        tdata_nx   = cmd_axis_tdata_o;
        lo_half_nx = lo_half;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                tvalid_nx = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    tdata_nx   = fifo_dout[WORD_W-1:CMD_STREAM_WIDTH];
                    lo_half_nx = fifo_dout[CMD_STREAM_WIDTH-1:0];
                    tvalid_nx  = 1'b1;
                    state_nx   = SEND_HI;
                end
            end
            SEND_HI: begin
                if (cmd_axis_tready_i) begin
                    tdata_nx = lo_half;
                    state_nx = SEND_LO;
                end
            end
            SEND_LO: begin
                if (cmd_axis_tready_i) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        tdata_nx   = fifo_dout[WORD_W-1:CMD_STREAM_WIDTH];
                        lo_half_nx = fifo_dout[CMD_STREAM_WIDTH-1:0];
                        state_nx   = SEND_HI;
                    end else begin
                        tvalid_nx = 1'b0;
                        state_nx  = IDLE;
                    end
                end
            end
            default: begin
                tvalid_nx = 1'b0;
                state_nx  = IDLE;
            end
        endcase
    end

    assign idle_o = fifo_empty && (state == IDLE);

`ifdef CMD_AXIS_TX_OVERFLOW_EN
    always_ff @(posedge clk) begin
        if (reset_i) begin
            overflow_o <= 1'b0;
        end else if (host_wr_i && host_full_o) begin
            overflow_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_axis_tx.sv
// tb/tb_cmd_axis_tx.sv - directed and scoreboard checks for cmd_axis_tx
module tb_cmd_axis_tx;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        host_wr_i = 1'b0;
    logic [31:0] host_data_i = '0;
    logic        host_full_o;
    logic [4:0]  host_level_o;
    logic        cmd_axis_tvalid_o;
    logic        cmd_axis_tready_i = 1'b0;
    logic [15:0] cmd_axis_tdata_o;
    logic        idle_o;
`ifdef CMD_AXIS_TX_OVERFLOW_EN
    logic        overflow_o;
`endif

    int errors = 0;
    int checks = 0;

    logic [15:0] beats[$];
    logic [31:0] exp_words[$];
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    cmd_axis_tx #(.CMD_STREAM_WIDTH(16), .FIFO_DEPTH(16)) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .host_wr_i         (host_wr_i),
        .host_data_i       (host_data_i),
        .host_full_o       (host_full_o),
        .host_level_o      (host_level_o),
        .cmd_axis_tvalid_o (cmd_axis_tvalid_o),
        .cmd_axis_tready_i (cmd_axis_tready_i),
        .cmd_axis_tdata_o  (cmd_axis_tdata_o),
        .idle_o            (idle_o)
`ifdef CMD_AXIS_TX_OVERFLOW_EN
        ,
        .overflow_o        (overflow_o)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge, so at the falling edge they hold the values the next edge will use.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (prev_stall && (cmd_axis_tvalid_o !== 1'b1 || cmd_axis_tdata_o !== prev_data))
                stall_viol++;
            if (cmd_axis_tvalid_o && cmd_axis_tready_i)
                beats.push_back(cmd_axis_tdata_o);
        end
        prev_stall = !reset_i && cmd_axis_tvalid_o && !cmd_axis_tready_i;
        prev_data  = cmd_axis_tdata_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        checks++; if (cmd_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", cmd_axis_tvalid_o); end
        checks++; if (cmd_axis_tdata_o !== 16'h0) begin errors++; $display("FAIL reset_tdata got=%h want=0000", cmd_axis_tdata_o); end
        checks++; if (host_full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", host_full_o); end
        checks++; if (host_level_o !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d want=0", host_level_o); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b want=1", idle_o); end
`ifdef CMD_AXIS_TX_OVERFLOW_EN
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow_o); end
`endif
    endtask

    task automatic test_single();
        beats.delete();
        cmd_axis_tready_i = 1'b1;
        host_wr_i = 1'b1;
        host_data_i = 32'h1234_ABCD;
        tick();
        host_wr_i = 1'b0;
        checks++; if (cmd_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL single_e0_tvalid got=%b want=0", cmd_axis_tvalid_o); end
        checks++; if (host_level_o !== 5'd1) begin errors++; $display("FAIL single_e0_level got=%0d want=1", host_level_o); end
        tick();
        checks++; if (cmd_axis_tvalid_o !== 1'b1 || cmd_axis_tdata_o !== 16'h1234) begin errors++; $display("FAIL single_beat0 got=%b/%h want=1/1234", cmd_axis_tvalid_o, cmd_axis_tdata_o); end
        tick();
        checks++; if (cmd_axis_tvalid_o !== 1'b1 || cmd_axis_tdata_o !== 16'hABCD) begin errors++; $display("FAIL single_beat1 got=%b/%h want=1/abcd", cmd_axis_tvalid_o, cmd_axis_tdata_o); end
        tick();
        checks++; if (cmd_axis_tvalid_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL single_end got tvalid=%b idle=%b want 0/1", cmd_axis_tvalid_o, idle_o); end
        checks++; if (beats.size() != 2) begin errors++; $display("FAIL single_beat_count got=%0d want=2", beats.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        logic [15:0] exp[6];
        int peak = 0;
        int run = 0;
        int bad = 0;
        w[0] = 32'h1111_2222; w[1] = 32'h3333_4444; w[2] = 32'h5555_6666;
        exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        beats.delete();
        cmd_axis_tready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_wr_i = 1'b1;
            host_data_i = w[i];
            tick();
            if (int'(host_level_o) > peak) peak = int'(host_level_o);
            if (cmd_axis_tvalid_o) run++;
        end
        host_wr_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (int'(host_level_o) > peak) peak = int'(host_level_o);
            if (cmd_axis_tvalid_o) run++;
        end
        checks++; if (peak != 2) begin errors++; $display("FAIL b2b_level_peak got=%0d want=2", peak); end
        checks++; if (run != 6) begin errors++; $display("FAIL b2b_valid_cycles got=%0d want=6", run); end
        checks++;
        if (beats.size() != 6) begin
            errors++; $display("FAIL b2b_beats got=%0d beats want=6", beats.size());
        end else begin
            for (int i = 0; i < 6; i++) if (beats[i] !== exp[i]) bad++;
            if (bad != 0) begin errors++; $display("FAIL b2b_beat_data got=%0d wrong beats want=0", bad); end
        end
    endtask

    task automatic test_stall();
        logic [4:0]  rdy;
        logic [15:0] exp[5];
        rdy = 5'b10100;
        exp = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h5555, 16'h5555};
        beats.delete();
        cmd_axis_tready_i = 1'b0;
        host_wr_i = 1'b1;
        host_data_i = 32'hAAAA_5555;
        tick();
        host_wr_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            cmd_axis_tready_i = rdy[i];
            checks++;
            if (cmd_axis_tvalid_o !== 1'b1 || cmd_axis_tdata_o !== exp[i]) begin
                errors++; $display("FAIL stall_step%0d got=%b/%h want=1/%h", i, cmd_axis_tvalid_o, cmd_axis_tdata_o, exp[i]);
            end
            tick();
        end
        checks++; if (cmd_axis_tvalid_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL stall_end got tvalid=%b idle=%b want 0/1", cmd_axis_tvalid_o, idle_o); end
        checks++;
        if (beats.size() != 2 || beats[0] !== 16'hAAAA || beats[1] !== 16'h5555)
            begin errors++; $display("FAIL stall_beats got count=%0d want 2 beats aaaa,5555", beats.size()); end
    endtask

    task automatic test_full();
        int bad = 0;
        int n = 0;
        beats.delete();
        cmd_axis_tready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            host_wr_i = 1'b1;
            host_data_i = {16'hC000 + 16'(i), 16'h3000 + 16'(i)};
            tick();
        end
        checks++; if (host_full_o !== 1'b1 || host_level_o !== 5'd16) begin errors++; $display("FAIL full_after17 got full=%b level=%0d want 1/16", host_full_o, host_level_o); end
`ifdef CMD_AXIS_TX_OVERFLOW_EN
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL overflow_early got=%b want=0", overflow_o); end
`endif
        host_data_i = 32'hDEAD_BEEF;
        tick();
        host_wr_i = 1'b0;
        checks++; if (host_full_o !== 1'b1 || host_level_o !== 5'd16) begin errors++; $display("FAIL full_after18 got full=%b level=%0d want 1/16", host_full_o, host_level_o); end
`ifdef CMD_AXIS_TX_OVERFLOW_EN
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b want=1", overflow_o); end
`endif
        cmd_axis_tready_i = 1'b1;
        while (!idle_o && n < 100) begin tick(); n++; end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL full_drain_timeout got idle=%b want=1", idle_o); end
        checks++;
        if (beats.size() != 34) begin
            errors++; $display("FAIL full_drain_beats got=%0d want=34", beats.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                if (beats[2*i] !== 16'hC000 + 16'(i) || beats[2*i+1] !== 16'h3000 + 16'(i)) bad++;
            end
            if (bad != 0) begin errors++; $display("FAIL full_drain_order got=%0d wrong words want=0", bad); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        beats.delete();
        cmd_axis_tready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            host_wr_i = 1'b1;
            host_data_i = 32'h7700_0000 + 32'(i);
            tick();
        end
        host_wr_i = 1'b0;
        checks++; if (cmd_axis_tvalid_o !== 1'b1 || host_level_o !== 5'd4) begin errors++; $display("FAIL rmid_pre got tvalid=%b level=%0d want 1/4", cmd_axis_tvalid_o, host_level_o); end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        checks++; if (cmd_axis_tvalid_o !== 1'b0 || host_level_o !== 5'd0 || idle_o !== 1'b1) begin errors++; $display("FAIL rmid_post got tvalid=%b level=%0d idle=%b want 0/0/1", cmd_axis_tvalid_o, host_level_o, idle_o); end
`ifdef CMD_AXIS_TX_OVERFLOW_EN
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rmid_overflow got=%b want=0", overflow_o); end
`endif
        beats.delete();
        cmd_axis_tready_i = 1'b1;
        host_wr_i = 1'b1;
        host_data_i = 32'h0BAD_F00D;
        tick();
        host_wr_i = 1'b0;
        while (!idle_o && n < 20) begin tick(); n++; end
        checks++;
        if (beats.size() != 2 || beats[0] !== 16'h0BAD || beats[1] !== 16'hF00D)
            begin errors++; $display("FAIL rmid_fresh got count=%0d want 2 beats 0bad,f00d", beats.size()); end
    endtask

    task automatic test_random();
        int bad = 0;
        int n = 0;
        beats.delete();
        exp_words.delete();
        stall_viol = 0;
        for (int c = 0; c < 10000; c++) begin
            cmd_axis_tready_i = ($urandom_range(2) != 0);
            // Outstanding words bound the FIFO count from above, so a push below 15 is always accepted.
            if ($urandom_range(1) == 1 && (exp_words.size() - beats.size() / 2) < 15) begin
                host_wr_i = 1'b1;
                host_data_i = $urandom;
                exp_words.push_back(host_data_i);
            end else begin
                host_wr_i = 1'b0;
            end
            tick();
        end
        host_wr_i = 1'b0;
        cmd_axis_tready_i = 1'b1;
        while (!idle_o && n < 100) begin tick(); n++; end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL rand_drain_timeout got idle=%b want=1", idle_o); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand_stall_stability got=%0d violations want=0", stall_viol); end
        checks++;
        if (beats.size() != 2 * exp_words.size()) begin
            errors++; $display("FAIL rand_beat_count got=%0d want=%0d", beats.size(), 2 * exp_words.size());
        end else begin
            for (int i = 0; i < exp_words.size(); i++) begin
                if (beats[2*i] !== exp_words[i][31:16] || beats[2*i+1] !== exp_words[i][15:0]) bad++;
            end
            if (bad != 0) begin errors++; $display("FAIL rand_beat_data got=%0d wrong words want=0", bad); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_full();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
